// File: rtl/seg_seq_pkg.sv
// Shared encodings and index helpers for the segment symbol sequencer.
package seg_seq_pkg;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CODE_W  = 8;
    localparam int unsigned STATE_W = 2;

    localparam logic [CODE_W-1:0] BLANK_CODE = CODE_W'(0);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_AUTO = 2'd2
    } seq_state_e;

    // One-hot decoder select for a symbol index.
    function automatic logic [CODE_W-1:0] idx_to_code(input logic [IDX_W-1:0] idx);
        return CODE_W'(1) << idx;
    endfunction

    // Advance an index by one in either direction, wrapping within 0..last.
    function automatic logic [IDX_W-1:0] step_idx(
        input logic [IDX_W-1:0] idx,
        input logic             down,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] nxt;
        if (down) begin
            nxt = (idx == IDX_W'(0)) ? last : idx - IDX_W'(1);
        end else begin
            nxt = (idx == last) ? IDX_W'(0) : idx + IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-sample counter and
// a one-cycle event on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;

    // Synchronizer keeps running regardless of enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
        end
    end

    // cnt_q counts consecutive synced samples that disagree with the accepted level.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        if (ena_i) begin
            if (sync2_q != lvl_q) begin
                if (cnt_q == CNT_LAST) begin
                    lvl_d  = sync2_q;
                    cnt_d  = '0;
                    rise_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/seg_symbol_sequencer.sv
// Symbol index sequencer driving the one-hot segment decoder select,
// stepped by debounced buttons or a prescaled auto-run tick.
module seg_symbol_sequencer
    import seg_seq_pkg::*;
#(
    parameter int unsigned NUM_SYMS   = 8,
    parameter int unsigned PRESCALE   = 10_000_000,
    parameter int unsigned DEB_CYCLES = 50_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               btn_step,
    input  logic               btn_load,
    input  logic               run,
    input  logic               dir,
    input  logic [IDX_W-1:0]   load_idx,
    output logic [CODE_W-1:0]  sym_code,
    output logic [IDX_W-1:0]   sym_idx,
    output logic               step_pulse,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned PRESC_W = $clog2(PRESCALE);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_SYMS - 1);

    logic step_ev;
    logic load_ev;
    logic run_s1_q, run_s2_q;
    logic dir_s1_q, dir_s2_q;

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               pulse_q, pulse_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               tick_c;
    logic [IDX_W-1:0]   load_val_c;
    logic [IDX_W-1:0]   next_idx_c;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena_i  (ena),
        .btn_i  (btn_step),
        .rise_o (step_ev)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena_i  (ena),
        .btn_i  (btn_load),
        .rise_o (load_ev)
    );

    // Level inputs only need synchronizing; they are not debounced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
        end else begin
            run_s1_q <= run;
            run_s2_q <= run_s1_q;
            dir_s1_q <= dir;
            dir_s2_q <= dir_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            code_q  <= BLANK_CODE;
            pulse_q <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
            presc_q <= presc_d;
        end
    end

    assign tick_c     = (presc_q == PRESC_LAST);
    assign load_val_c = (32'(load_idx) >= NUM_SYMS) ? IDX_LAST : load_idx;
    assign next_idx_c = step_idx(idx_q, dir_s2_q, IDX_LAST);

    // Priority: load > step > tick; leaving AUTO suppresses the tick but keeps a load.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        if (ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_ev) begin
                        state_d = ST_SHOW;
                        idx_d   = load_val_c;
                    end else if (step_ev) begin
                        state_d = ST_SHOW;
                    end else if (run_s2_q) begin
                        state_d = ST_AUTO;
                        presc_d = '0;
                    end
                end
                ST_SHOW: begin
                    if (load_ev) begin
                        idx_d = load_val_c;
                    end else if (step_ev) begin
                        idx_d = next_idx_c;
                    end
                    if (run_s2_q) begin
                        state_d = ST_AUTO;
                        presc_d = '0;
                    end
                end
                ST_AUTO: begin
                    if (!run_s2_q) begin
                        state_d = ST_SHOW;
                        if (load_ev) begin
                            idx_d = load_val_c;
                        end
                    end else if (load_ev) begin
                        idx_d   = load_val_c;
                        presc_d = '0;
                    end else if (tick_c) begin
                        idx_d   = next_idx_c;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            code_d  = (state_d == ST_IDLE) ? BLANK_CODE : idx_to_code(idx_d);
            pulse_d = (idx_d != idx_q) || (code_d != code_q);
        end
    end

    assign sym_code   = code_q;
    assign sym_idx    = idx_q;
    assign step_pulse = pulse_q;
    assign state      = STATE_W'(state_q);

endmodule
